flag_register: RTL and testbench

Holds the processor's N/Z/C/V condition flags and drives the `flag` input of the condition tester. Flags are loaded from the ALU on flag-setting instructions that pass their condition, or written directly by a status-register move. A shadow stack saves flags on exception entry and restores them on exception return. The block sits between the execute-stage ALU and the condition tester; its registered output is the flag state the next instruction is evaluated against.

---
 rtl/flag_register.sv | 102 ++++++++++
 tb/tb_flag_register.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/flag_register.sv
// N/Z/C/V condition-flag register with a LIFO shadow stack for exception entry and return.
// All outputs are flops: one-cycle latency, with no combinational path from any input.
module flag_register #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   alu_flags,
  input  logic                         alu_valid,
  input  logic                         set_flags,
  input  logic                         cond_pass,
  input  logic                         wr_en,
  input  logic [3:0]                   wr_data,
  input  logic                         exc_entry,
  input  logic                         exc_return,
  input  logic                         clr_err,
  output logic [3:0]                   flag,
  output logic [$clog2(DEPTH+1)-1:0]   stack_depth,
  output logic                         ovf_err,
  output logic                         unf_err
);

  localparam int DW = $clog2(DEPTH + 1);

  // Sized to the full index range so the depth counter can address it without truncation.
  logic [3:0]    r_stack [0:(1 << DW) - 1];
  logic [3:0]    r_flag;
  logic [DW-1:0] r_depth;
  logic          r_ovf;
  logic          r_unf;

  logic [3:0]    w_flag_nxt;
  logic [DW-1:0] w_depth_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_set;
  logic          w_unf_set;
  logic          w_full;
  logic          w_empty;
  logic [DW-1:0] w_top_idx;

  assign w_full    = (r_depth == DW'(DEPTH));
  assign w_empty   = (r_depth == '0);
  assign w_top_idx = r_depth - DW'(1);

  always_comb begin
    w_flag_nxt  = r_flag;
    w_depth_nxt = r_depth;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    // Exception entry squashes everything else in the cycle, including a return.
    if (exc_entry) begin
      if (!w_full) begin
        w_push      = 1'b1;
        w_depth_nxt = r_depth + DW'(1);
      end else begin
        w_ovf_set = 1'b1;
      end
    end else if (exc_return) begin
      if (!w_empty) begin
        w_pop       = 1'b1;
        w_flag_nxt  = r_stack[w_top_idx];
        w_depth_nxt = w_top_idx;
      end else begin
        w_unf_set = 1'b1;
      end
    end else if (wr_en) begin
      w_flag_nxt = wr_data;
    end else if (alu_valid && set_flags && cond_pass) begin
      w_flag_nxt = alu_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag  <= 4'b0000;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_flag  <= w_flag_nxt;
      r_depth <= w_depth_nxt;
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (clr_err) r_ovf <= 1'b0;
      if (w_unf_set)    r_unf <= 1'b1;
      else if (clr_err) r_unf <= 1'b0;
    end
  end

  // Stack contents are don't-care after reset, so no reset is applied here.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_depth] <= r_flag;
  end

  assign flag        = r_flag;
  assign stack_depth = r_depth;
  assign ovf_err     = r_ovf;
  assign unf_err     = r_unf;

endmodule

// File: tb/tb_flag_register.sv
// Directed self-checking bench for flag_register with DEPTH=4.
module tb_flag_register;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] alu_flags;
  logic       alu_valid, set_flags, cond_pass;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       exc_entry, exc_return, clr_err;
  logic [3:0] flag;
  logic [2:0] stack_depth;
  logic       ovf_err, unf_err;

  int checks = 0;
  int errors = 0;

  flag_register #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_flags(alu_flags), .alu_valid(alu_valid), .set_flags(set_flags), .cond_pass(cond_pass),
    .wr_en(wr_en), .wr_data(wr_data),
    .exc_entry(exc_entry), .exc_return(exc_return), .clr_err(clr_err),
    .flag(flag), .stack_depth(stack_depth), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_flags = 4'b0000; alu_valid = 1'b0; set_flags = 1'b0; cond_pass = 1'b0;
    wr_en = 1'b0; wr_data = 4'b0000;
    exc_entry = 1'b0; exc_return = 1'b0; clr_err = 1'b0;
  endtask

  // Apply the currently driven inputs for one edge, then return them to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk_all(input string tag, input logic [3:0] f, input logic [2:0] d,
                         input logic o, input logic u);
    chk({tag, ".flag"}, {4'b0, flag}, {4'b0, f});
    chk({tag, ".depth"}, {5'b0, stack_depth}, {5'b0, d});
    chk({tag, ".ovf"}, {7'b0, ovf_err}, {7'b0, o});
    chk({tag, ".unf"}, {7'b0, unf_err}, {7'b0, u});
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'b0000, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // ALU update gated by valid/S/cond
    alu_valid = 1; set_flags = 1; cond_pass = 1; alu_flags = 4'b1010; tick();
    chk("alu_load", {4'b0, flag}, 8'h0a);
    alu_valid = 1; set_flags = 1; cond_pass = 0; alu_flags = 4'b0101; tick();
    chk("alu_cond_fail", {4'b0, flag}, 8'h0a);
    alu_valid = 1; set_flags = 0; cond_pass = 1; alu_flags = 4'b0101; tick();
    chk("alu_no_s", {4'b0, flag}, 8'h0a);

    // Direct write beats ALU
    wr_en = 1; wr_data = 4'b0110; alu_valid = 1; set_flags = 1; cond_pass = 1; alu_flags = 4'b1111; tick();
    chk("wr_over_alu", {4'b0, flag}, 8'h06);

    // Nested exception push/pop
    exc_entry = 1; tick();
    chk_all("push1", 4'b0110, 3'd1, 1'b0, 1'b0);
    wr_en = 1; wr_data = 4'b1001; tick();
    chk("wr_1001", {4'b0, flag}, 8'h09);
    exc_entry = 1; wr_en = 1; wr_data = 4'b1111; tick();
    chk_all("push2_squash_wr", 4'b1001, 3'd2, 1'b0, 1'b0);
    wr_en = 1; wr_data = 4'b0011; tick();
    chk("wr_0011", {4'b0, flag}, 8'h03);
    exc_return = 1; wr_en = 1; wr_data = 4'b1111; tick();
    chk_all("pop1", 4'b1001, 3'd1, 1'b0, 1'b0);
    exc_return = 1; tick();
    chk_all("pop2", 4'b0110, 3'd0, 1'b0, 1'b0);

    // Overflow: five pushes into a 4-deep stack
    for (int i = 1; i <= 4; i++) begin
      exc_entry = 1; tick();
      chk("fill_depth", {5'b0, stack_depth}, 8'(i));
      chk("fill_ovf", {7'b0, ovf_err}, 8'h00);
    end
    exc_entry = 1; tick();
    chk_all("push5_ovf", 4'b0110, 3'd4, 1'b1, 1'b0);
    exc_entry = 1; clr_err = 1; tick();
    chk_all("ovf_set_beats_clr", 4'b0110, 3'd4, 1'b1, 1'b0);
    clr_err = 1; tick();
    chk_all("ovf_clr", 4'b0110, 3'd4, 1'b0, 1'b0);

    // Drain, then underflow with a discarded ALU update
    for (int i = 3; i >= 0; i--) begin
      exc_return = 1; tick();
      chk("drain_depth", {5'b0, stack_depth}, 8'(i));
    end
    exc_return = 1; alu_valid = 1; set_flags = 1; cond_pass = 1; alu_flags = 4'b1111; tick();
    chk_all("pop_empty_unf", 4'b0110, 3'd0, 1'b0, 1'b1);
    clr_err = 1; tick();
    chk("unf_clr", {7'b0, unf_err}, 8'h00);

    // Simultaneous entry and return: entry wins
    wr_en = 1; wr_data = 4'b1100; tick();
    exc_entry = 1; exc_return = 1; tick();
    chk_all("entry_and_return", 4'b1100, 3'd1, 1'b0, 1'b0);
    wr_en = 1; wr_data = 4'b0001; tick();
    chk("wr_0001", {4'b0, flag}, 8'h01);
    exc_return = 1; tick();
    chk_all("entry0_restored", 4'b1100, 3'd0, 1'b0, 1'b0);

    // Async reset mid-cycle
    exc_return = 1; tick();
    chk("unf_before_rst", {7'b0, unf_err}, 8'h01);
    exc_entry = 1; tick();
    exc_entry = 1; tick();
    chk("depth_before_rst", {5'b0, stack_depth}, 8'h02);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 4'b0000, 3'd0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    alu_valid = 1; set_flags = 1; cond_pass = 1; alu_flags = 4'b0111; tick();
    chk_all("after_rst", 4'b0111, 3'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
